instruction_queue: RTL

- FIFO between instruction fetch and dispatch.
- Buffers fetched instruction/PC pairs and issues at most one per cycle to the decoder, reorder buffer, RS and LSB.
- Issue is gated by downstream back-pressure.
- Flushed entirely on roll_back (branch mispredict).

---
 rtl/instruction_queue_if.sv | 28 ++
 rtl/instruction_queue.sv | 110 +++++++++++
 2 files changed

// File: rtl/instruction_queue_if.sv
// Fetch-side and issue-side signal bundle of the instruction queue.
// The queue connects through the slave modport; fetch/downstream models use master.
interface instruction_queue_if #(
  parameter int ADDR_W = 4
);
  logic              ifu_valid;
  logic [31:0]       ifu_ins;
  logic [31:0]       ifu_pc;
  logic              isq_full;
  logic              isq_almost_full;
  logic              rob_is_full;
  logic              rs_is_full;
  logic              lsb_is_full;
  logic              get_instruction;
  logic [31:0]       isq_ins_out;
  logic [31:0]       isq_pc_out;
  logic [ADDR_W:0]   isq_count;

  modport master (
    output ifu_valid, ifu_ins, ifu_pc, rob_is_full, rs_is_full, lsb_is_full,
    input  isq_full, isq_almost_full, get_instruction, isq_ins_out, isq_pc_out, isq_count
  );

  modport slave (
    input  ifu_valid, ifu_ins, ifu_pc, rob_is_full, rs_is_full, lsb_is_full,
    output isq_full, isq_almost_full, get_instruction, isq_ins_out, isq_pc_out, isq_count
  );
endinterface

// File: rtl/instruction_queue.sv
// Instruction FIFO between fetch and dispatch, issuing at most one entry per cycle.
// Optional macro ISQ_BYPASS_EN: an instruction arriving at an empty queue goes straight to the outputs.
module instruction_queue #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  instruction_queue_if.slave isq
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

  logic [31:0]       mem_ins [DEPTH];
  logic [31:0]       mem_pc  [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              get_q, get_d;
  logic [31:0]       ins_q, ins_d;
  logic [31:0]       pc_q, pc_d;

  logic              ds_ready;
  logic              push;
  logic              pop;
  logic              bypass;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    get_d    = 1'b0;
    ins_d    = ins_q;
    pc_d     = pc_q;
    ds_ready = !isq.rob_is_full && !isq.rs_is_full && !isq.lsb_is_full;
    push     = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;

    if (roll_back) begin
      // Mispredict flush: drop everything, including a same-cycle fetch.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy_in) begin
      pop = (count_q != '0) && ds_ready;
`ifdef ISQ_BYPASS_EN
      bypass = (count_q == '0) && isq.ifu_valid && ds_ready;
`endif
      // When full, a push is still accepted if a pop frees the head slot this cycle.
      push = isq.ifu_valid && !bypass && ((count_q != FULL_CNT) || pop);

      if (push) tail_d = tail_q + 1'b1;
      if (pop) begin
        head_d = head_q + 1'b1;
        ins_d  = mem_ins[head_q];
        pc_d   = mem_pc[head_q];
        get_d  = 1'b1;
      end
      if (bypass) begin
        ins_d = isq.ifu_ins;
        pc_d  = isq.ifu_pc;
        get_d = 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      get_q   <= 1'b0;
      ins_q   <= '0;
      pc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      get_q   <= get_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
    end
  end

  // Storage is never reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_ins[tail_q] <= isq.ifu_ins;
      mem_pc[tail_q]  <= isq.ifu_pc;
    end
  end

  assign isq.isq_full        = (count_q == FULL_CNT);
  assign isq.isq_almost_full = (count_q >= AF_CNT);
  assign isq.get_instruction = get_q;
  assign isq.isq_ins_out     = ins_q;
  assign isq.isq_pc_out      = pc_q;
  assign isq.isq_count       = count_q;
endmodule
